conv_operand_packer: RTL and testbench

- Front-end feeder for the 32-lane 4-bit dot-product convolution engine.
- Accepts byte-serial weight and IFM streams and packs each 16 bytes into a 128-bit word.
- Drives the engine's In_Weight/weight_valid and In_IFM/in_valid inputs.
- Holds weights stable across any number of IFM vectors and reloads them only on a vector boundary.

---
 rtl/conv_operand_packer_pkg.sv | 16 +
 rtl/conv_operand_packer_if.sv | 31 +++
 rtl/conv_operand_packer_byte_word_packer.sv | 40 ++++
 rtl/conv_operand_packer.sv | 90 +++++++++
 tb/tb_conv_operand_packer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/conv_operand_packer_pkg.sv
// rtl/conv_operand_packer_pkg.sv - shared constants and types for the conv operand packer
// Contents: BYTES/WORD_W/NIB_W/LANES geometry, counter width, FSM state enum.
package conv_operand_packer_pkg;

  localparam int BYTES  = 16;
  localparam int WORD_W = 8 * BYTES;
  localparam int NIB_W  = 4;
  localparam int LANES  = WORD_W / NIB_W;
  localparam int CNT_B  = $clog2(BYTES);

  typedef enum logic {
    W_LOAD = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/conv_operand_packer_if.sv
// rtl/conv_operand_packer_if.sv - byte streams in, packed engine operands out
// Signals: w_valid/w_ready/w_data (weight bytes), x_valid/x_ready/x_data (IFM bytes),
//          In_Weight/weight_valid, In_IFM/in_valid (engine side), vec_cnt (IFM words emitted).
// Modports: master = stream source / engine side, slave = packer.
interface conv_operand_packer_if
  import conv_operand_packer_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              w_valid;
  logic              w_ready;
  logic [7:0]        w_data;
  logic              x_valid;
  logic              x_ready;
  logic [7:0]        x_data;
  logic [WORD_W-1:0] In_Weight;
  logic              weight_valid;
  logic [WORD_W-1:0] In_IFM;
  logic              in_valid;
  logic [CNT_W-1:0]  vec_cnt;

  modport master (
    output w_valid, w_data, x_valid, x_data,
    input  w_ready, x_ready, In_Weight, weight_valid, In_IFM, in_valid, vec_cnt
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data,
    output w_ready, x_ready, In_Weight, weight_valid, In_IFM, in_valid, vec_cnt
  );
endinterface

// File: rtl/conv_operand_packer_byte_word_packer.sv
// rtl/conv_operand_packer_byte_word_packer.sv - byte counter, staging buffer and completion strobe
// Ports: clk, rst_n, beat (byte accepted this cycle), data (byte), cnt (bytes already staged),
//        word (complete word, valid when done), done (this beat completes the word).
module byte_word_packer #(
  parameter int BYTES = 16,
  parameter int CW    = $clog2(BYTES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat,
  input  logic [7:0]         data,
  output logic [CW-1:0]      cnt,
  output logic [8*BYTES-1:0] word,
  output logic               done
);

  logic [8*BYTES-1:0] stage;
  logic [CW+2:0]      lsb;

  assign lsb  = {cnt, 3'b000};
  assign done = beat && (cnt == CW'(BYTES - 1));

  // The final byte is merged combinationally so the full word can be
  // registered downstream on the same edge that accepts it.
  always_comb begin
    word = stage;
    word[8*BYTES-1 -: 8] = data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
      cnt   <= '0;
    end else if (beat) begin
      stage[lsb +: 8] <= data;
      cnt             <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_operand_packer.sv
// rtl/conv_operand_packer.sv - packs byte-serial weight/IFM streams into 128-bit engine operands
// Ports: clk, rst_n (async, active-low), bus (slave modport: byte streams in,
//        In_Weight/weight_valid, In_IFM/in_valid, vec_cnt out).
module conv_operand_packer
  import conv_operand_packer_pkg::*;
#(
  parameter int BYTES = conv_operand_packer_pkg::BYTES,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_operand_packer_if.slave bus
);

  localparam int CW = $clog2(BYTES);

  state_t             state, state_nx;
  logic               w_ready_c, x_ready_c;
  logic               w_beat, x_beat;
  logic               w_done, x_done;
  logic [CW-1:0]      w_cnt, x_cnt;
  logic [8*BYTES-1:0] w_word, x_word;
  logic [CNT_W-1:0]   vec_q;

  assign w_beat = bus.w_valid && w_ready_c;
  assign x_beat = bus.x_valid && x_ready_c;

  byte_word_packer #(.BYTES(BYTES)) u_w_pack (
    .clk(clk), .rst_n(rst_n), .beat(w_beat), .data(bus.w_data),
    .cnt(w_cnt), .word(w_word), .done(w_done)
  );

  byte_word_packer #(.BYTES(BYTES)) u_x_pack (
    .clk(clk), .rst_n(rst_n), .beat(x_beat), .data(bus.x_data),
    .cnt(x_cnt), .word(x_word), .done(x_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      W_LOAD:  if (w_done) state_nx = RUN;
      RUN:     if (w_beat) state_nx = W_LOAD;
      default: state_nx = W_LOAD;
    endcase
  end

  // A weight reload may only start on an IFM word boundary, and when both
  // streams offer at that boundary the weight byte wins.
  always_comb begin
    w_ready_c = 1'b0;
    x_ready_c = 1'b0;
    case (state)
      W_LOAD: w_ready_c = 1'b1;
      RUN: begin
        w_ready_c = (x_cnt == '0);
        x_ready_c = !((x_cnt == '0) && bus.w_valid);
      end
      default: ;
    endcase
  end

  assign bus.w_ready = w_ready_c;
  assign bus.x_ready = x_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.In_Weight    <= '0;
      bus.weight_valid <= 1'b0;
      bus.In_IFM       <= '0;
      bus.in_valid     <= 1'b0;
      vec_q            <= '0;
    end else begin
      bus.weight_valid <= w_done;
      bus.in_valid     <= x_done;
      if (w_done) bus.In_Weight <= w_word;
      if (x_done) begin
        bus.In_IFM <= x_word;
        vec_q      <= vec_q + 1'b1;
      end
    end
  end

  assign bus.vec_cnt = vec_q;

endmodule

// File: tb/tb_conv_operand_packer.sv
// tb/tb_conv_operand_packer.sv - self-checking bench for conv_operand_packer
module tb_conv_operand_packer;
  import conv_operand_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_operand_packer_if #(.CNT_W(16)) bus();

  conv_operand_packer #(.BYTES(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    bit wv; byte unsigned wd; bit xv; byte unsigned xd;
    bit e_wr; bit e_xr; bit e_wvld; bit e_ivld;
  } vec_t;

  // stream-level reference model: byte lists of the words in progress
  byte unsigned wq[$];
  byte unsigned xq[$];
  bit           w_loaded;
  logic [127:0] m_weight, m_ifm;
  bit           m_wv, m_iv;
  int unsigned  m_vec;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  s_wr, s_xr;
  int  cyc = 0;
  int  t_iv[$];

  function automatic logic [127:0] pack(input byte unsigned q[$]);
    logic [127:0] r = '0;
    foreach (q[k]) r = r | (128'(q[k]) << (8 * k));
    return r;
  endfunction

  function automatic bit in_wload();
    return !w_loaded || wq.size() != 0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    wq.delete(); xq.delete();
    w_loaded = 0; m_weight = '0; m_ifm = '0; m_wv = 0; m_iv = 0; m_vec = 0;
  endtask

  task automatic cycle(input bit wv, input byte unsigned wd, input bit xv, input byte unsigned xd);
    bit e_wr, e_xr;
    bus.w_valid = wv; bus.w_data = wd; bus.x_valid = xv; bus.x_data = xd;
    #1;
    e_wr = in_wload() || xq.size() == 0;
    e_xr = !in_wload() && !(xq.size() == 0 && wv);
    s_wr = bus.w_ready; s_xr = bus.x_ready;
    chk("w_ready", 128'(s_wr), 128'(e_wr));
    chk("x_ready", 128'(s_xr), 128'(e_xr));
    @(posedge clk);
    cyc++;
    m_wv = 0; m_iv = 0;
    if (wv && e_wr) begin
      wq.push_back(wd);
      if (wq.size() == 16) begin m_weight = pack(wq); wq.delete(); w_loaded = 1; m_wv = 1; end
    end
    if (xv && e_xr) begin
      xq.push_back(xd);
      if (xq.size() == 16) begin m_ifm = pack(xq); xq.delete(); m_vec++; m_iv = 1; end
    end
    #1;
    if (bus.in_valid) t_iv.push_back(cyc);
    chk("weight_valid", 128'(bus.weight_valid), 128'(m_wv));
    chk("in_valid", 128'(bus.in_valid), 128'(m_iv));
    chk("In_Weight", bus.In_Weight, m_weight);
    chk("In_IFM", bus.In_IFM, m_ifm);
    chk("vec_cnt", 128'(bus.vec_cnt), 128'(m_vec[15:0]));
  endtask

  task automatic do_reset();
    bus.w_valid = 0; bus.x_valid = 0; bus.w_data = 0; bus.x_data = 0;
    #1; rst_n = 0; #1;
    model_reset();
    chk("rst_In_Weight", bus.In_Weight, '0);
    chk("rst_In_IFM", bus.In_IFM, '0);
    chk("rst_weight_valid", 128'(bus.weight_valid), 128'(0));
    chk("rst_in_valid", 128'(bus.in_valid), 128'(0));
    chk("rst_vec_cnt", 128'(bus.vec_cnt), 128'(0));
    chk("rst_w_ready", 128'(bus.w_ready), 128'(1));
    chk("rst_x_ready", 128'(bus.x_ready), 128'(0));
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic align_run_empty();
    for (int i = 0; i < 100 && (in_wload() || xq.size() != 0); i++)
      cycle(in_wload(), 8'($urandom), !in_wload(), 8'($urandom));
    if (in_wload() || xq.size() != 0) begin
      n_chk++;
      $display("FAIL align: could not reach an IFM word boundary in RUN");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[19];
    int t0;
    tbl[0] = '{1, 8'h60, 1, 8'h44, 1, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 1, 8'h45, 1, 0, 0, 0};
    for (int i = 1; i < 16; i++)
      tbl[i+1] = '{1, 8'(8'h60 + i), 1, 8'h46, 1, 0, (i == 15), 0};
    tbl[17] = '{0, 8'h00, 1, 8'h71, 1, 1, 0, 0};
    tbl[18] = '{1, 8'hAA, 1, 8'h72, 0, 1, 0, 0};

    do_reset();

    // weight load with x offered throughout (must be refused)
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h10 + i), 1, 8'hEE);
    chk("first_weight", bus.In_Weight, 128'h1F1E1D1C1B1A19181716151413121110);

    // two gapless IFM words
    t_iv.delete();
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'(i));
    chk("ifm_word0", bus.In_IFM, 128'h0F0E0D0C0B0A09080706050403020100);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'(8'h80 + i));
    chk("ifm_word1", bus.In_IFM, 128'h8F8E8D8C8B8A89888786858483828180);
    chk("vec_cnt_2", 128'(bus.vec_cnt), 128'(2));
    if (t_iv.size() == 2) chk("pulse_gap", 128'(t_iv[1] - t_iv[0]), 128'(16));
    else chk("pulse_count", 128'(t_iv.size()), 128'(2));

    // weight request mid-word waits for the IFM word boundary
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 8'(8'h20 + i));
    cycle(1, 8'hAA, 1, 8'h27);
    chk("midword_w_refused", 128'(s_wr), 128'(0));
    for (int i = 1; i < 9; i++) cycle(1, 8'hAA, 1, 8'(8'h27 + i));
    chk("midword_word_done", 128'(bus.in_valid), 128'(1));
    cycle(1, 8'hAA, 1, 8'h55);
    chk("boundary_w_taken", 128'(s_wr), 128'(1));
    chk("boundary_x_refused", 128'(s_xr), 128'(0));
    cycle(0, 0, 1, 8'h56);
    chk("wload_x_blocked", 128'(s_xr), 128'(0));
    for (int i = 0; i < 14; i++) cycle(1, 8'($urandom), 1'($urandom_range(0, 1)), 8'h00);
    chk("weight_held_reload", bus.In_Weight, 128'h1F1E1D1C1B1A19181716151413121110);
    cycle(1, 8'h99, 0, 0);
    chk("reload_weight_valid", 128'(bus.weight_valid), 128'(1));

    // table: collision at the boundary, full reload, then a mid-word weight request
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].wv, tbl[i].wd, tbl[i].xv, tbl[i].xd);
      chk($sformatf("tbl%0d_w_ready", i), 128'(s_wr), 128'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_x_ready", i), 128'(s_xr), 128'(tbl[i].e_xr));
      chk($sformatf("tbl%0d_weight_valid", i), 128'(bus.weight_valid), 128'(tbl[i].e_wvld));
      chk($sformatf("tbl%0d_in_valid", i), 128'(bus.in_valid), 128'(tbl[i].e_ivld));
    end

    // randomized traffic against the model
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 9) < 6), 8'($urandom));

    // gapped IFM word must match the gapless packing
    align_run_empty();
    begin
      int k = 0;
      for (int i = 0; i < 200 && k < 16; i++) begin
        bit v = ($urandom_range(0, 2) != 0);
        cycle(0, 0, v, 8'(k));
        if (v) k++;
      end
      chk("gapped_in_valid", 128'(bus.in_valid), 128'(1));
      chk("gapped_word", bus.In_IFM, 128'h0F0E0D0C0B0A09080706050403020100);
    end

    // reset at x_cnt = 9 discards the partial word
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 8'(8'h30 + i));
    do_reset();
    t0 = t_iv.size();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h3F);
    chk("no_partial_emit", 128'(t_iv.size() - t0), 128'(0));

    // recovery after reset
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'(8'hB0 + i));
    chk("recover_vec_cnt", 128'(bus.vec_cnt), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
